// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the MM:SS BCD countdown timer.
// Holds the FSM state encoding, digit limits and the load clamp helper.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } state_e;

  localparam logic [3:0] SEC_TENS_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX    = 4'd9;

  function automatic logic [3:0] clamp_digit(input logic [3:0] val, input logic [3:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/countdown_timer_bcd_down_digit.sv
// One BCD down-counting digit: load has priority over decrement, and
// decrementing from zero reloads the digit maximum and raises borrow.
module bcd_down_digit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld,
  input  logic [3:0] ld_val,
  input  logic [3:0] max,
  input  logic       dec,
  output logic [3:0] q,
  output logic       is_zero,
  output logic       borrow
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (dec) begin
      q_d = (q_q == 4'd0) ? max : (q_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign is_zero = (q_q == 4'd0);
  assign borrow  = dec & (q_q == 4'd0);

endmodule

// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer driven by the rising edge of the divided tick.
// Holds the control FSM, tick edge detector, load clamp and borrow chain.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter logic [3:0] MAX_MIN_TENS = 4'd9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       load,
  input  logic [7:0] ld_min,
  input  logic [7:0] ld_sec,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       ack,
  output logic [7:0] min_bcd,
  output logic [7:0] sec_bcd,
  output logic       running,
  output logic       expired,
  output logic       done
);

  state_e     state_q, state_d;
  logic       done_q, done_d;
  logic       tick_d_q;
  logic       tick_rise;

  logic       ld_en, ld_zero, count_en;
  logic [3:0] so_q, st_q, mo_q, mt_q;
  logic       so_zero, st_zero, mo_zero, mt_zero;
  logic       so_borrow, st_borrow, mo_borrow, mt_borrow;
  logic       count_zero, count_one;
  logic [3:0] so_ld, st_ld, mo_ld, mt_ld;

  assign tick_rise  = tick_in & ~tick_d_q;
  assign count_zero = so_zero & st_zero & mo_zero & mt_zero;
  assign count_one  = (so_q == 4'd1) & st_zero & mo_zero & mt_zero;

  // clear reuses the digit load path with an all-zero value
  assign so_ld = ld_zero ? 4'd0 : clamp_digit(ld_sec[3:0], DIGIT_MAX);
  assign st_ld = ld_zero ? 4'd0 : clamp_digit(ld_sec[7:4], SEC_TENS_MAX);
  assign mo_ld = ld_zero ? 4'd0 : clamp_digit(ld_min[3:0], DIGIT_MAX);
  assign mt_ld = ld_zero ? 4'd0 : clamp_digit(ld_min[7:4], MAX_MIN_TENS);

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    ld_en    = 1'b0;
    ld_zero  = 1'b0;
    count_en = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      ld_en   = 1'b1;
      ld_zero = 1'b1;
    end else if (load && (state_q != ST_RUN)) begin
      state_d = ST_IDLE;
      ld_en   = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_PAUSE: begin
          if (start && !count_zero) state_d = ST_RUN;
        end
        ST_RUN: begin
          // pause beats a coincident tick; that tick is dropped
          if (pause) begin
            state_d = ST_PAUSE;
          end else if (tick_rise && !count_zero) begin
            count_en = 1'b1;
            if (count_one) begin
              state_d = ST_EXPIRED;
              done_d  = 1'b1;
            end
          end
        end
        ST_EXPIRED: begin
          if (ack) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      tick_d_q <= tick_in;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      tick_d_q <= tick_in;
    end
  end

  bcd_down_digit u_sec_ones (
    .clk(clk), .rst_n(rst_n), .ld(ld_en), .ld_val(so_ld), .max(DIGIT_MAX),
    .dec(count_en), .q(so_q), .is_zero(so_zero), .borrow(so_borrow)
  );

  bcd_down_digit u_sec_tens (
    .clk(clk), .rst_n(rst_n), .ld(ld_en), .ld_val(st_ld), .max(SEC_TENS_MAX),
    .dec(so_borrow), .q(st_q), .is_zero(st_zero), .borrow(st_borrow)
  );

  bcd_down_digit u_min_ones (
    .clk(clk), .rst_n(rst_n), .ld(ld_en), .ld_val(mo_ld), .max(DIGIT_MAX),
    .dec(st_borrow), .q(mo_q), .is_zero(mo_zero), .borrow(mo_borrow)
  );

  bcd_down_digit u_min_tens (
    .clk(clk), .rst_n(rst_n), .ld(ld_en), .ld_val(mt_ld), .max(MAX_MIN_TENS),
    .dec(mo_borrow), .q(mt_q), .is_zero(mt_zero), .borrow(mt_borrow)
  );

  assign min_bcd = {mt_q, mo_q};
  assign sec_bcd = {st_q, so_q};
  assign running = (state_q == ST_RUN);
  assign expired = (state_q == ST_EXPIRED);
  assign done    = done_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: drivers push expected outputs into a
// queue and a negedge monitor pops and compares them against the DUT.
module tb_countdown_timer;

  localparam int W = 19;  // {min[7:0], sec[7:0], running, expired, done}

  logic       clk;
  logic       rst_n;
  logic       tick_in;
  logic       load;
  logic [7:0] ld_min;
  logic [7:0] ld_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic       ack;
  logic [7:0] min_bcd;
  logic [7:0] sec_bcd;
  logic       running;
  logic       expired;
  logic       done;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           done_cnt = 0;

  countdown_timer #(.MAX_MIN_TENS(4'd9)) dut (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .load(load),
    .ld_min(ld_min), .ld_sec(ld_sec), .start(start), .pause(pause),
    .clear(clear), .ack(ack), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
    .running(running), .expired(expired), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d checks pending", exp_q.size());
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
    if (exp_q.size() != 0) begin
      logic [W-1:0] e, a;
      string        nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {min_bcd, sec_bcd, running, expired, done};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got min=%h sec=%h run=%b exp=%b done=%b, want min=%h sec=%h run=%b exp=%b done=%b",
                 nm, a[18:11], a[10:3], a[2], a[1], a[0], e[18:11], e[10:3], e[2], e[1], e[0]);
      end
    end
  end

  // driver tasks; every task starts and ends 1 time unit after a posedge
  task automatic cyc(input logic l, input logic s, input logic p, input logic c,
                     input logic a, input logic t, input logic [7:0] m, input logic [7:0] sc);
    load = l; start = s; pause = p; clear = c; ack = a; tick_in = t;
    ld_min = m; ld_sec = sc;
    @(posedge clk); #1;
    load = 0; start = 0; pause = 0; clear = 0; ack = 0;
    if (t) begin
      tick_in = 0;
      @(posedge clk); #1;
    end
  endtask

  task automatic do_load(input logic [7:0] m, input logic [7:0] sc);
    cyc(1, 0, 0, 0, 0, 0, m, sc);
  endtask

  task automatic do_start();
    cyc(0, 1, 0, 0, 0, 0, 8'h00, 8'h00);
  endtask

  task automatic do_tick();
    cyc(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
  endtask

  task automatic expect_out(input string nm, input logic [7:0] m, input logic [7:0] sc,
                            input logic r, input logic ex, input logic d);
    exp_q.push_back({m, sc, r, ex, d});
    name_q.push_back(nm);
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic expect_done_cnt(input string nm, input int want);
    n_checks++;
    if (done_cnt != want) begin
      n_fail++;
      $display("FAIL %s: done pulse count got %0d, want %0d", nm, done_cnt, want);
    end
  endtask

  initial begin
    rst_n = 0; tick_in = 1; load = 0; start = 0; pause = 0; clear = 0; ack = 0;
    ld_min = 0; ld_sec = 0;
    repeat (3) @(posedge clk);
    #1;
    // 1: release reset with tick_in held high
    rst_n = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    expect_out("reset_release", 8'h00, 8'h00, 0, 0, 0);
    tick_in = 0;
    @(posedge clk); #1;
    expect_done_cnt("reset_no_done", 0);

    // 2: 01:00 counts down to expiry in 60 ticks
    do_load(8'h01, 8'h00);
    expect_out("load_0100", 8'h01, 8'h00, 0, 0, 0);
    do_start();
    expect_out("start_0100", 8'h01, 8'h00, 1, 0, 0);
    do_tick();
    expect_out("first_tick_0059", 8'h00, 8'h59, 1, 0, 0);
    for (int i = 0; i < 58; i++) do_tick();
    expect_out("tick59_0001", 8'h00, 8'h01, 1, 0, 0);
    expect_done_cnt("no_early_done", 0);
    do_tick();
    expect_out("tick60_expired", 8'h00, 8'h00, 0, 1, 0);
    expect_done_cnt("done_one_cycle", 1);
    do_start();
    expect_out("start_in_expired", 8'h00, 8'h00, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
    expect_out("ack_to_idle", 8'h00, 8'h00, 0, 0, 0);

    // 3: pause holds the count, resume finishes
    do_load(8'h00, 8'h03);
    do_start();
    do_tick();
    expect_out("pre_pause_0002", 8'h00, 8'h02, 1, 0, 0);
    cyc(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) do_tick();
    expect_out("paused_hold", 8'h00, 8'h02, 0, 0, 0);
    do_start();
    do_tick();
    expect_out("resume_0001", 8'h00, 8'h01, 1, 0, 0);
    do_tick();
    expect_out("resume_expire", 8'h00, 8'h00, 0, 1, 0);
    expect_done_cnt("done_after_resume", 2);

    // pause coincident with a tick rise: the tick is lost
    do_load(8'h00, 8'h05);
    do_start();
    cyc(0, 0, 1, 0, 0, 1, 8'h00, 8'h00);
    expect_out("pause_beats_tick", 8'h00, 8'h05, 0, 0, 0);

    // load with start: load wins
    do_load(8'h00, 8'h00);
    cyc(1, 1, 0, 0, 0, 0, 8'h00, 8'h07);
    expect_out("load_beats_start", 8'h00, 8'h07, 0, 0, 0);

    // 4: clamp and full borrow chain
    do_load(8'hA7, 8'h6F);
    expect_out("clamp_9759", 8'h97, 8'h59, 0, 0, 0);
    do_load(8'h10, 8'h00);
    do_start();
    do_tick();
    expect_out("borrow_0959", 8'h09, 8'h59, 1, 0, 0);
    cyc(0, 0, 0, 1, 0, 0, 8'h00, 8'h00);
    expect_out("clear_mid_run", 8'h00, 8'h00, 0, 0, 0);

    // 5: start at zero and load during run
    do_start();
    expect_out("start_at_zero", 8'h00, 8'h00, 0, 0, 0);
    expect_done_cnt("no_done_at_zero", 2);
    do_load(8'h00, 8'h05);
    do_start();
    do_load(8'h00, 8'h30);
    expect_out("load_in_run_ignored", 8'h00, 8'h05, 1, 0, 0);

    // 6: clear+load mid-run, then reset mid-run
    do_tick();
    expect_out("tick_0004", 8'h00, 8'h04, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0, 8'h12, 8'h34);
    expect_out("clear_beats_load", 8'h00, 8'h00, 0, 0, 0);
    do_load(8'h00, 8'h09);
    do_start();
    do_tick();
    expect_out("pre_reset_0008", 8'h00, 8'h08, 1, 0, 0);
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    expect_out("reset_mid_run", 8'h00, 8'h00, 0, 0, 0);
    expect_done_cnt("final_done_count", 2);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
